// File: rtl/apb_cmd_master.sv
// APB initiator: turns one request/response stream into APB transfers
// on the FC, CONV and POOL register ports, with a bounded PREADY wait.
module apb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic        PSEL_FC,
  output logic        PSEL_CONV,
  output logic        PSEL_POOL,
  input  logic [31:0] PRDATA_FC,
  input  logic [31:0] PRDATA_CONV,
  input  logic [31:0] PRDATA_POOL,
  input  logic        PREADY_FC,
  input  logic        PREADY_CONV,
  input  logic        PREADY_POOL,
  input  logic        PSLVERR_FC,
  input  logic        PSLVERR_CONV,
  input  logic        PSLVERR_POOL
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [2:0]    tgt;
  logic [2:0]    hit;
  logic [CW-1:0] cnt;
  logic          s_ready;
  logic          s_err;
  logic [31:0]   s_rdata;

  assign REQ_READY = (state == IDLE) & ~RESET;
  assign RSP_VALID = (state == RESP);

  always_comb begin
    hit = 3'b000;
    unique case (REQ_ADDR[31:28])
      4'h0:    hit = 3'b001;
      4'h1:    hit = 3'b010;
      4'h2:    hit = 3'b100;
      default: hit = 3'b000;
    endcase
  end

  // only the latched target's inputs are looked at
  always_comb begin
    s_ready = 1'b0;
    s_err   = 1'b0;
    s_rdata = '0;
    unique case (1'b1)
      tgt[0]: begin
        s_ready = PREADY_FC;
        s_err   = PSLVERR_FC;
        s_rdata = PRDATA_FC;
      end
      tgt[1]: begin
        s_ready = PREADY_CONV;
        s_err   = PSLVERR_CONV;
        s_rdata = PRDATA_CONV;
      end
      tgt[2]: begin
        s_ready = PREADY_POOL;
        s_err   = PSLVERR_POOL;
        s_rdata = PRDATA_POOL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      tgt       <= '0;
      cnt       <= '0;
      PSEL_FC   <= 1'b0;
      PSEL_CONV <= 1'b0;
      PSEL_POOL <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ_VALID) begin
            tgt    <= hit;
            PADDR  <= REQ_ADDR;
            PWRITE <= REQ_WRITE;
            PWDATA <= REQ_WDATA;
            cnt    <= '0;
            if (|hit) begin
              {PSEL_POOL, PSEL_CONV, PSEL_FC} <= hit;
              state <= SETUP;
            end else begin
              RSP_ERR   <= 2'b11;
              RSP_RDATA <= '0;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (s_ready) begin
            {PSEL_POOL, PSEL_CONV, PSEL_FC} <= 3'b000;
            PENABLE   <= 1'b0;
            RSP_ERR   <= s_err ? 2'b01 : 2'b00;
            RSP_RDATA <= (!s_err && !PWRITE) ? s_rdata : '0;
            state     <= RESP;
          end else if (cnt == LAST) begin
            {PSEL_POOL, PSEL_CONV, PSEL_FC} <= 3'b000;
            PENABLE   <= 1'b0;
            RSP_ERR   <= 2'b10;
            RSP_RDATA <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (RSP_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB initiator that programs the FC, CONV and POOL accelerators' APB register ports from a single request/response stream. Each request is one 32-bit read or write. The top nibble of the request address selects one of three PSEL lines. The block runs the APB SETUP/ACCESS sequence, waits on the selected slave's PREADY with a bounded timeout, and returns read data plus a status code. It sits between the control sequencer and the accelerators' APB slave ports.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of ACCESS cycles to wait for PREADY before aborting; must be ≥1.

Ports:
- CLK  in  1  single clock; all logic is rising-edge.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted on the cycle REQ_VALID and REQ_READY are both high.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  32  byte address; [31:28] selects the slave.
- REQ_WDATA  in  32  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  32  read data; 0 for writes and errors.
- RSP_ERR  out  2  status: 00 OK, 01 slave error (PSLVERR), 10 timeout, 11 decode error.
- PADDR  out  32  APB address (full REQ_ADDR).
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB enable.
- PSEL_FC, PSEL_CONV, PSEL_POOL  out  1 each  APB selects.
- PRDATA_FC, PRDATA_CONV, PRDATA_POOL  in  32 each  slave read data.
- PREADY_FC, PREADY_CONV, PREADY_POOL  in  1 each  slave ready.
- PSLVERR_FC, PSLVERR_CONV, PSLVERR_POOL  in  1 each  slave error.

## Operation
- Decode on REQ_ADDR[31:28]:
  - 0x0 → FC.
  - 0x1 → CONV.
  - 0x2 → POOL.
  - Any other value → decode error; no APB activity.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - REQ_READY = 1.
  - On accept, latch write, address, write data and target.
  - Hit → SETUP. Miss → RESP with RSP_ERR = 11 and RSP_RDATA = 0.
- SETUP:
  - Selected PSEL_x = 1, PENABLE = 0.
  - Lasts exactly one cycle, then → ACCESS.
  - Clear the wait counter on entry.
- ACCESS:
  - Selected PSEL_x = 1, PENABLE = 1.
  - Sample only the selected slave's PREADY, PSLVERR and PRDATA.
  - PREADY = 1 → RESP. RSP_ERR = PSLVERR ? 01 : 00. RSP_RDATA = PRDATA for an OK read; otherwise 0.
  - PREADY = 0 → increment the counter. After TIMEOUT_CYCLES ACCESS cycles without PREADY → RESP with RSP_ERR = 10 and RSP_RDATA = 0.
  - PREADY arriving in the final allowed cycle wins over the timeout.
- RESP:
  - RSP_VALID = 1.
  - RSP_RDATA and RSP_ERR held stable until RSP_READY = 1, then → IDLE.
  - REQ_READY = 0.
- Unselected slaves' PREADY, PSLVERR and PRDATA are ignored in every state, including X values.
- Counter width: clog2(TIMEOUT_CYCLES+1). No wrap is possible because the timeout terminates counting first.

## Timing
- Reset values:
  - State = IDLE.
  - All PSEL_x, PENABLE, PWRITE, RSP_VALID = 0.
  - PADDR, PWDATA, RSP_RDATA = 0, RSP_ERR = 00.
  - REQ_READY = 0 while RESET is high, and 1 in the first cycle after RESET drops.
- Registered outputs:
  - PSEL_x and PENABLE are driven from state registers.
  - REQ_READY and RSP_VALID are decoded from state; neither depends combinationally on REQ_VALID or RSP_READY.
- Latency, taking accept at cycle 0:
  - PSEL_x rises at cycle 1.
  - PENABLE is high from cycle 2.
  - With zero wait states, RSP_VALID is high at cycle 3.
  - If RSP_READY is high at cycle 3, REQ_READY is high at cycle 4.
  - Minimum 4 cycles per transfer.
- Decode error: RSP_VALID at cycle 1.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE and RESP.
- PENABLE and PSEL_x drop on the clock edge after the cycle where PREADY is seen or the timeout occurs.
- At most one PSEL_x is high at any time.
- Reset mid-transaction:
  - On the next edge, PSEL_x, PENABLE and RSP_VALID go to 0.
  - The pending request and its response are discarded.
  - No response is issued for the discarded request.
- REQ_VALID during SETUP, ACCESS or RESP is not accepted and has no effect.

## Test plan
- Write CONV: addr 0x1000_0008, data 0xDEADBEEF, PREADY_CONV tied 1.
  - PSEL_CONV high in cycles 1–2 only; PENABLE high in cycle 2 only.
  - PWDATA = 0xDEADBEEF throughout.
  - RSP_VALID in cycle 3 with RSP_ERR = 00 and RSP_RDATA = 0.
- Read FC: addr 0x0000_0004; PREADY_FC low for 3 ACCESS cycles, then high with PRDATA_FC = 0x1234_5678.
  - PENABLE high for exactly 4 cycles.
  - RSP_RDATA = 0x1234_5678, RSP_ERR = 00.
- Read POOL with PREADY_POOL = 1 and PSLVERR_POOL = 1, PRDATA_POOL = 0xFFFF_FFFF.
  - RSP_ERR = 01, RSP_RDATA = 0.
  - PSEL_FC and PSEL_CONV never assert.
- Addr 0x3000_0000.
  - No PSEL_x or PENABLE assertion.
  - RSP_VALID in cycle 1 with RSP_ERR = 11.
- TIMEOUT_CYCLES = 4, PREADY never asserted.
  - PENABLE high for exactly 4 cycles, then RSP_ERR = 10.
  - Repeat with PREADY asserted in the 4th ACCESS cycle: RSP_ERR = 00.
- Backpressure and reset:
  - Hold RSP_READY low for 5 cycles with REQ_VALID high: response fields stay stable, REQ_READY stays 0, and a second request is accepted only after the handshake.
  - Assert RESET in an ACCESS cycle: PSEL_x, PENABLE and RSP_VALID are 0 on the next edge, and no response appears.
